// File: rtl/fp_mul_round_pipe.sv
// fp_mul_round_pipe: normalize, round-to-nearest-even and pack a binary32 product over two handshaked stages
module fp_mul_round_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp_a,
  input  logic [EXP_W-1:0]        in_exp_b,
  input  logic                    in_frac_nz_a,
  input  logic                    in_frac_nz_b,
  input  logic [2*FRAC_W+1:0]     in_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic [3:0]              out_flags
);
  localparam int MW = FRAC_W + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EW-1:0] E_OVF = EW'(2**EXP_W - 1);
  localparam logic [EXP_W+FRAC_W:0] QNAN = {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};

  logic                  r_s1_valid;
  logic                  r_s1_sign;
  logic                  r_s1_special;
  logic [EXP_W+FRAC_W:0] r_s1_spec_res;
  logic [3:0]            r_s1_spec_flags;
  logic [MW-1:0]         r_s1_m;
  logic                  r_s1_g;
  logic                  r_s1_s;
  logic [EW-1:0]         r_s1_e;
  logic                  r_s2_valid;
  logic [EXP_W+FRAC_W:0] r_s2_result;
  logic [3:0]            r_s2_flags;

  logic                  w_s1_adv, w_s2_adv;
  logic                  w_nan, w_inf_a, w_inf_b, w_zero_a, w_zero_b, w_invalid, w_special;
  logic [EXP_W+FRAC_W:0] w_spec_res;
  logic                  w_hi;
  logic [MW-1:0]         w_m;
  logic                  w_g, w_s;
  logic [EW-1:0]         w_e;
  logic                  w_rnd, w_carry, w_ovf, w_unf;
  logic [MW:0]           w_mr;
  logic [FRAC_W-1:0]     w_frac;
  logic [EW-1:0]         w_e2;
  logic [EXP_W+FRAC_W:0] w_res;
  logic [3:0]            w_flags;

  assign w_s2_adv   = !r_s2_valid | out_ready;
  assign w_s1_adv   = !r_s1_valid | w_s2_adv;
  assign in_ready   = w_s1_adv;
  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_flags  = r_s2_flags;

  // Stage 1: classify operands (denormals read as zero) and normalize the raw product to 24 bits plus guard/sticky
  always_comb begin
    w_zero_a   = in_exp_a == '0;
    w_zero_b   = in_exp_b == '0;
    w_inf_a    = (in_exp_a == EMAX) & !in_frac_nz_a;
    w_inf_b    = (in_exp_b == EMAX) & !in_frac_nz_b;
    w_nan      = ((in_exp_a == EMAX) & in_frac_nz_a) | ((in_exp_b == EMAX) & in_frac_nz_b);
    w_invalid  = (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b);
    w_special  = w_nan | w_inf_a | w_inf_b | w_zero_a | w_zero_b;
    w_spec_res = (w_nan | w_invalid) ? QNAN :
                 (w_inf_a | w_inf_b) ? {in_sign, EMAX, {FRAC_W{1'b0}}} :
                 {in_sign, {(EXP_W+FRAC_W){1'b0}}};
    w_hi       = in_prod[PW-1];
    w_m        = w_hi ? in_prod[PW-1 -: MW] : in_prod[PW-2 -: MW];
    w_g        = w_hi ? in_prod[PW-MW-1] : in_prod[PW-MW-2];
    w_s        = w_hi ? |in_prod[PW-MW-2:0] : |in_prod[PW-MW-3:0];
    w_e        = EW'(in_exp_a) + EW'(in_exp_b) - (w_hi ? EW'(BIAS - 1) : EW'(BIAS));
  end

  // Stage 1 register: captures a beat whenever the stage is empty or draining into stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign       <= in_sign;
        r_s1_special    <= w_special;
        r_s1_spec_res   <= w_spec_res;
        r_s1_spec_flags <= {w_invalid, 3'b000};
        r_s1_m          <= w_m;
        r_s1_g          <= w_g;
        r_s1_s          <= w_s;
        r_s1_e          <= w_e;
      end
    end
  end

  // Stage 2: round to nearest-even, renormalize on mantissa carry, then range-check the rounded exponent
  always_comb begin
    w_rnd   = r_s1_g & (r_s1_s | r_s1_m[0]);
    w_mr    = {1'b0, r_s1_m} + {{MW{1'b0}}, w_rnd};
    w_carry = w_mr[MW];
    w_frac  = w_carry ? {FRAC_W{1'b0}} : w_mr[FRAC_W-1:0];
    w_e2    = r_s1_e + {{(EW-1){1'b0}}, w_carry};
    w_ovf   = !w_e2[EW-1] & (w_e2 >= E_OVF);
    w_unf   = w_e2[EW-1] | (w_e2 == '0);
    w_res   = r_s1_special ? r_s1_spec_res :
              w_ovf ? {r_s1_sign, EMAX, {FRAC_W{1'b0}}} :
              w_unf ? {r_s1_sign, {(EXP_W+FRAC_W){1'b0}}} :
              {r_s1_sign, w_e2[EXP_W-1:0], w_frac};
    w_flags = r_s1_special ? r_s1_spec_flags :
              {1'b0, w_ovf, w_unf, r_s1_g | r_s1_s | w_ovf | w_unf};
  end

  // Stage 2 register: result and flags only change when a new beat moves in, so they hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_res;
        r_s2_flags  <= w_flags;
      end
    end
  end
endmodule
